// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - Moore main control FSM for the multicycle 32-bit datapath
module multicycle_main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] aluop,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regwrite,
  output logic       memwrite,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t cur_state;
  state_t nxt_state;

  // State register; reset always returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state selection; op matters only in DECODE and MEMADR, unknown codes recover to FETCH.
  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH: nxt_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt_state = S_MEMADR;
          OP_RTYPE:     nxt_state = S_EXECUTE;
          OP_BEQ:       nxt_state = S_BEQEX;
          OP_ADDI:      nxt_state = S_ADDIEX;
          OP_J:         nxt_state = S_JEX;
          default:      nxt_state = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        case (op)
          OP_LW:   nxt_state = S_MEMRD;
          OP_SW:   nxt_state = S_MEMWR;
          default: nxt_state = S_FETCH;
        endcase
      end
      S_MEMRD:   nxt_state = S_MEMWB;
      S_EXECUTE: nxt_state = S_ALUWB;
      S_ADDIEX:  nxt_state = S_ADDIWB;
      default:   nxt_state = S_FETCH;
    endcase
  end

  // Moore output decode of the registered state; everything defaults to 0.
  always_comb begin
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    aluop    = 2'b00;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    case (cur_state)
      S_FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = cur_state;

endmodule
